img_pixel_framer: RTL and testbench

IMG_PIXEL_FRAMER -- requirements
Module: img_pixel_framer

---
 rtl/axi_stream_if.sv | 39 +++
 rtl/img_pixel_framer.sv | 211 +++++++++++++++++++++
 tb/tb_img_pixel_framer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_if.sv
// AXI4-Stream style pixel bus shared by the framer's input and output ports.
// Default widths come from AXIS_TDATA_WIDTH / AXIS_TUSER_WIDTH when the
// integration does not provide them.

`ifndef AXIS_TDATA_WIDTH
`define AXIS_TDATA_WIDTH 8
`endif
`ifndef AXIS_TUSER_WIDTH
`define AXIS_TUSER_WIDTH 1
`endif

interface axi_stream_if #(
    parameter int unsigned DATA_W = `AXIS_TDATA_WIDTH,
    parameter int unsigned USER_W = `AXIS_TUSER_WIDTH
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    // Producer side
    modport master (
        output tdata,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    // Consumer side
    modport slave (
        input  tdata,
        input  tuser,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/img_pixel_framer.sv
// img_pixel_framer: tags a raw pixel stream with SOF (tuser[0]) and EOL (tlast)
// using column/row counters, and forwards it through a 2-entry skid buffer.
// Optional feature macro: IMG_PIXEL_FRAMER_RESYNC_EN -- when defined, an input
// beat carrying tuser[0]=1 away from pixel (0,0) restarts framing at that beat
// and pulses resync_err; when undefined, input tuser is ignored.

`ifndef AXIS_TDATA_WIDTH
`define AXIS_TDATA_WIDTH 8
`endif
`ifndef AXIS_TUSER_WIDTH
`define AXIS_TUSER_WIDTH 1
`endif
`ifndef IMG_W
`define IMG_W 640
`endif
`ifndef IMG_H
`define IMG_H 480
`endif

module img_pixel_framer #(
    parameter int unsigned TDATA_WIDTH = `AXIS_TDATA_WIDTH,
    parameter int unsigned TUSER_WIDTH = `AXIS_TUSER_WIDTH,
    parameter int unsigned FRAME_W     = `IMG_W,
    parameter int unsigned FRAME_H     = `IMG_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    axi_stream_if.slave  s_axis,
    axi_stream_if.master m_axis,
    output logic       busy,
    output logic       frame_done,
    output logic       resync_err
);

    localparam int unsigned COL_W = $clog2(FRAME_W);
    localparam int unsigned ROW_W = $clog2(FRAME_H);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(FRAME_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(FRAME_H - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // One buffered output beat plus its framing tags
    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic                   sof;
        logic                   eol;
        logic                   eof;
    } beat_t;

    state_t             state;
    state_t             state_nxt;
    logic [COL_W-1:0]   col_cntr;
    logic [ROW_W-1:0]   row_cntr;

    // Skid buffer: entry 0 drives m_axis, entry 1 catches a beat during a stall
    beat_t              ent0;
    beat_t              ent1;
    logic               vld0;
    logic               vld1;

    logic               s_ready_c;
    logic               busy_c;
    logic               accept_c;
    logic               pop_c;
    logic               resync_hit_c;
    logic               at_origin_c;
    logic               at_eol_c;
    logic               at_eof_c;
    beat_t              new_beat_c;
    logic [TUSER_WIDTH-1:0] m_user_c;

    // Input tlast never affects framing; input tuser only matters with resync
    logic               unused_in;
    assign unused_in = ^{1'b0, s_axis.tlast, s_axis.tuser};

    assign accept_c = s_axis.tvalid & s_ready_c;
    assign pop_c    = vld0 & m_axis.tready;

    // Resync detect: a SOF-marked input beat anywhere other than pixel (0,0)
`ifdef IMG_PIXEL_FRAMER_RESYNC_EN
    assign resync_hit_c = s_axis.tuser[0] & ~at_origin_c;
`else
    assign resync_hit_c = 1'b0;
`endif

    // Position tags for the beat currently offered on s_axis
    always_comb begin
        at_origin_c = (col_cntr == '0) && (row_cntr == '0);
        at_eol_c    = ~resync_hit_c && (col_cntr == COL_MAX);
        at_eof_c    = at_eol_c && (row_cntr == ROW_MAX);
        new_beat_c.data = s_axis.tdata;
        new_beat_c.sof  = at_origin_c | resync_hit_c;
        new_beat_c.eol  = at_eol_c;
        new_beat_c.eof  = at_eof_c;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: continuous is only looked at on the frame's last pixel
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (accept_c && at_eof_c && !continuous) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs: accept input while active and the skid buffer has room
    always_comb begin
        s_ready_c = 1'b0;
        busy_c    = vld0 | vld1;
        if (state == S_ACTIVE) begin
            s_ready_c = ~vld1;
            busy_c    = 1'b1;
        end
    end

    assign s_axis.tready = s_ready_c;
    assign busy          = busy_c;

    // Column/row position of the next input beat
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cntr <= '0;
            row_cntr <= '0;
        end else if (accept_c) begin
            if (resync_hit_c) begin
                col_cntr <= COL_W'(1);
                row_cntr <= '0;
            end else if (col_cntr == COL_MAX) begin
                col_cntr <= '0;
                row_cntr <= (row_cntr == ROW_MAX) ? '0 : row_cntr + ROW_W'(1);
            end else begin
                col_cntr <= col_cntr + COL_W'(1);
            end
        end
    end

    // Skid buffer update; entry 1 only fills while entry 0 is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (pop_c) begin
            if (vld1) begin
                ent0 <= ent1;
                vld1 <= 1'b0;
            end else if (accept_c) begin
                ent0 <= new_beat_c;
            end else begin
                vld0 <= 1'b0;
            end
        end else if (accept_c) begin
            if (!vld0) begin
                ent0 <= new_beat_c;
                vld0 <= 1'b1;
            end else begin
                ent1 <= new_beat_c;
                vld1 <= 1'b1;
            end
        end
    end

    // Status pulses: frame end after the last pixel leaves, resync after detection
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            frame_done <= pop_c & ent0.eof;
            resync_err <= accept_c & resync_hit_c;
        end
    end

    // Output sideband: only bit 0 (SOF) is ever set
    always_comb begin
        m_user_c    = '0;
        m_user_c[0] = ent0.sof;
    end

    assign m_axis.tvalid = vld0;
    assign m_axis.tdata  = ent0.data;
    assign m_axis.tlast  = ent0.eol;
    assign m_axis.tuser  = m_user_c;

endmodule

// File: tb/tb_img_pixel_framer.sv
// Scoreboard bench for img_pixel_framer with a 4x3 frame.
`timescale 1ns/1ps
module tb_img_pixel_framer;
    localparam int unsigned DW = 8;
    localparam int unsigned UW = 2;
    localparam int unsigned FW = 4;
    localparam int unsigned FH = 3;
`ifdef IMG_PIXEL_FRAMER_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic continuous;
    logic busy;
    logic frame_done;
    logic resync_err;

    axi_stream_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
    axi_stream_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    img_pixel_framer #(
        .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .FRAME_W(FW), .FRAME_H(FH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .s_axis(s_if), .m_axis(m_if),
        .busy(busy), .frame_done(frame_done), .resync_err(resync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int fd_cnt = 0;
    int re_cnt = 0;
    int stall_cnt = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    bit mon_en = 1'b0;
    bit rand_rdy = 1'b0;
    bit fd_pending = 1'b0;
    bit prev_stall = 1'b0;
    logic [11:0] prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input bit sof, input bit eol, input bit eof);
        exp_t e;
        e.data = d; e.sof = sof; e.eol = eol; e.eof = eof;
        return e;
    endfunction

    // Monitor: pops the scoreboard on each output handshake, watches stalls and pulses
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !reset) begin
            if (prev_stall)
                check("stall_hold", 32'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}), 32'(prev_out));
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_out = {1'b1, m_if.tdata, m_if.tuser, m_if.tlast};
            if (fd_pending || frame_done)
                check("frame_done_timing", 32'(frame_done), 32'(fd_pending));
            fd_pending = 1'b0;
            if (frame_done) fd_cnt++;
            if (resync_err) re_cnt++;
            if (acc_cnt - out_cnt >= 2)
                check("full_blocks_tready", 32'(s_if.tready), 32'd0);
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", 32'(m_if.tdata), 32'(e.data));
                    check("tuser", 32'(m_if.tuser), 32'({1'b0, e.sof}));
                    check("tlast", 32'(m_if.tlast), 32'(e.eol));
                    fd_pending = e.eof;
                end
                out_cnt++;
            end
            if (s_if.tvalid && s_if.tready) acc_cnt++;
        end
    end

    // Random output back-pressure when enabled
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one beat and wait (bounded) until it is accepted; ends at posedge+1
    task automatic send(input logic [DW-1:0] d, input logic [UW-1:0] u, input exp_t e);
        int waits = 0;
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tuser = u; s_if.tlast = 1'b0;
        @(negedge clk);
        while (!s_if.tready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!s_if.tready) begin
            check("accept_timeout", 32'(waits), 32'd0);
            @(posedge clk); #1;
            s_if.tvalid = 1'b0;
        end else begin
            stall_cnt += waits;
            @(posedge clk); #1;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata, s_if.tready, busy, frame_done, resync_err}), 32'd0);
    endtask

    task automatic check_frame_end(input string tag, input int fd_exp, input int fd0);
        @(negedge clk);
        check({tag, "_tready_idle"}, 32'(s_if.tready), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_frame_done_count"}, 32'(fd_cnt - fd0), 32'(fd_exp));
        check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int fd0;
        int re0;
        int pos;
        int nb;
        reset = 1'b1; start = 1'b0; continuous = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        cycles(3);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1 reset = 1'b0;
        mon_en = 1'b1;

        // Single frame, full rate
        continuous = 1'b0; fd0 = fd_cnt; stall_cnt = 0;
        pulse_start();
        for (int i = 0; i < 12; i++)
            send(8'(i + 1), 2'b00, mk(8'(i + 1), i == 0, (i % 4) == 3, i == 11));
        s_if.tvalid = 1'b0;
        cycles(5);
        check("t1_no_stalls", 32'(stall_cnt), 32'd0);
        check_frame_end("t1", 1, fd0);

        // Two back-to-back frames; continuous drops mid second frame
        continuous = 1'b1; fd0 = fd_cnt; stall_cnt = 0;
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            if (i == 13) continuous = 1'b0;
            send(8'(i + 1), 2'b10, mk(8'(i + 1), (i % 12) == 0, (i % 4) == 3, (i % 12) == 11));
        end
        s_if.tvalid = 1'b0;
        cycles(5);
        check("t2_no_gap", 32'(stall_cnt), 32'd0);
        check_frame_end("t2", 2, fd0);

        // Random back-pressure against a full-rate source
        continuous = 1'b0; fd0 = fd_cnt;
        rand_rdy = 1'b1;
        pulse_start();
        for (int i = 0; i < 12; i++)
            send(8'(8'h20 + i), 2'b00, mk(8'(8'h20 + i), i == 0, (i % 4) == 3, i == 11));
        s_if.tvalid = 1'b0;
        cycles(3);
        rand_rdy = 1'b0;
        m_if.tready = 1'b1;
        cycles(6);
        check_frame_end("t3", 1, fd0);

        // Reset after beat 6 discards the frame; restart needs a new start
        pulse_start();
        for (int i = 0; i < 6; i++)
            send(8'(8'h41 + i), 2'b00, mk(8'(8'h41 + i), i == 0, (i % 4) == 3, 1'b0));
        reset = 1'b1; s_if.tvalid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset");
        @(posedge clk); #1 reset = 1'b0;
        exp_q.delete();
        acc_cnt = 0; out_cnt = 0; prev_stall = 1'b0; fd_pending = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = 8'h99;
        cycles(3);
        @(negedge clk);
        check("no_restart_without_start", 32'(s_if.tready), 32'd0);
        @(posedge clk); #1 s_if.tvalid = 1'b0;
        fd0 = fd_cnt;
        pulse_start();
        for (int i = 0; i < 12; i++)
            send(8'(8'h50 + i), 2'b00, mk(8'(8'h50 + i), i == 0, (i % 4) == 3, i == 11));
        s_if.tvalid = 1'b0;
        cycles(5);
        check_frame_end("t4", 1, fd0);
        check("no_resync_so_far", 32'(re_cnt), 32'd0);

        // Input SOF on beat 6
        fd0 = fd_cnt; re0 = re_cnt;
        nb = RESYNC ? 17 : 12;
        pulse_start();
        for (int b = 1; b <= nb; b++) begin
            pos = (RESYNC && b >= 6) ? b - 6 : b - 1;
            send(8'(8'h60 + b), (b == 6) ? 2'b01 : 2'b00,
                 mk(8'(8'h60 + b), pos == 0, (pos % 4) == 3, pos == 11));
        end
        s_if.tvalid = 1'b0;
        cycles(5);
        check("t5_resync_err_count", 32'(re_cnt - re0), RESYNC ? 32'd1 : 32'd0);
        check_frame_end("t5", 1, fd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
